fallthrough_pkt_fifo: RTL and testbench

//  First-word-fall-through FIFO for the user data path with a registered head stage, programmable

---
 rtl/fifo_pkg.sv | 22 ++
 rtl/pkt_fifo_ram.sv | 61 ++++++
 rtl/fallthrough_pkt_fifo.sv | 118 +++++++++++
 tb/tb_fallthrough_pkt_fifo.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared definitions for the fall-through packet FIFO.
// Holds the default sizing, the clog2 helper and the head-stage state encoding.
package fifo_pkg;

    localparam int DEFAULT_DEPTH_BITS = 3;

    localparam logic [0:0] HEAD_EMPTY = 1'b0;
    localparam logic [0:0] HEAD_VALID = 1'b1;

    function automatic int clog2(input int value);
        int result;
        int remaining;
        result    = 0;
        remaining = value - 1;
        while (remaining > 0) begin
            result++;
            remaining = remaining >> 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/pkt_fifo_ram.sv
// Circular word array behind the head register: DEPTH entries of data plus eop bit.
// The caller guarantees it never writes while full nor reads while empty.
module pkt_fifo_ram
    import fifo_pkg::*;
#(
    parameter int WIDTH          = 72,
    parameter int MAX_DEPTH_BITS = DEFAULT_DEPTH_BITS
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      wr_en,
    input  logic [WIDTH:0]            wr_data,
    input  logic                      rd_en,
    output logic [WIDTH:0]            rd_data,
    output logic [MAX_DEPTH_BITS:0]   count,
    output logic                      empty,
    output logic                      full,
    output logic                      nearly_full
);

    localparam int DEPTH = 1 << MAX_DEPTH_BITS;
    localparam int PTR_W = (clog2(DEPTH) > 0) ? clog2(DEPTH) : 1;
    localparam int CNT_W = MAX_DEPTH_BITS + 1;

    logic [WIDTH:0]   mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;

    // Storage has no reset: stale contents are unreachable once the pointers clear.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (rd_en) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({wr_en, rd_en})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    assign rd_data     = mem[rd_ptr];
    assign empty       = (count == '0);
    assign full        = (count == CNT_W'(DEPTH));
    assign nearly_full = (count >= CNT_W'(DEPTH - 1));

endmodule

// File: rtl/fallthrough_pkt_fifo.sv
// First-word-fall-through FIFO: word array plus a registered head stage, with
// programmable thresholds, sticky error flags and optional store-and-forward packet mode.
module fallthrough_pkt_fifo
    import fifo_pkg::*;
#(
    parameter int WIDTH                = 72,
    parameter int MAX_DEPTH_BITS       = DEFAULT_DEPTH_BITS,
    parameter int PROG_FULL_THRESHOLD  = 2**MAX_DEPTH_BITS - 1,
    parameter int PROG_EMPTY_THRESHOLD = 1,
    parameter int PACKET_MODE          = 0
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic [WIDTH-1:0]          din,
    input  logic                      din_eop,
    input  logic                      wr_en,
    input  logic                      rd_en,
    output logic [WIDTH-1:0]          dout,
    output logic                      dout_eop,
    output logic                      empty,
    output logic                      full,
    output logic                      nearly_full,
    output logic                      prog_full,
    output logic                      prog_empty,
    output logic [MAX_DEPTH_BITS:0]   data_count,
    output logic [MAX_DEPTH_BITS:0]   pkt_count,
    output logic                      overflow,
    output logic                      underflow
);

    localparam int CNT_W = MAX_DEPTH_BITS + 1;
    localparam logic [CNT_W:0] PF_THRESHOLD = (CNT_W + 1)'(PROG_FULL_THRESHOLD);
    localparam logic [CNT_W:0] PE_THRESHOLD = (CNT_W + 1)'(PROG_EMPTY_THRESHOLD);

    logic [WIDTH:0]   arr_rd_data;
    logic [CNT_W-1:0] arr_count;
    logic             arr_empty;
    logic             arr_full;
    logic             arr_nearly_full;

    logic [0:0] head_state;
    logic       wr_accept;
    logic       pop;
    logic       load_permit;
    logic       head_load;
    logic       pkt_inc;
    logic       pkt_dec;

    // Full is judged on the array alone, so a same-cycle pop never makes room for a write.
    assign wr_accept = reset_n && wr_en && !arr_full;
    assign pop       = reset_n && rd_en && (head_state == HEAD_VALID);

    // A full array forces a head load in packet mode so oversized packets cut through.
    assign load_permit = !arr_empty && ((PACKET_MODE == 0) || (pkt_count != '0) || arr_full);
    assign head_load   = reset_n && load_permit && ((head_state == HEAD_EMPTY) || pop);

    pkt_fifo_ram #(
        .WIDTH          (WIDTH),
        .MAX_DEPTH_BITS (MAX_DEPTH_BITS)
    ) u_ram (
        .clk         (clk),
        .reset_n     (reset_n),
        .wr_en       (wr_accept),
        .wr_data     ({din_eop, din}),
        .rd_en       (head_load),
        .rd_data     (arr_rd_data),
        .count       (arr_count),
        .empty       (arr_empty),
        .full        (arr_full),
        .nearly_full (arr_nearly_full)
    );

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            head_state <= HEAD_EMPTY;
            dout       <= '0;
            dout_eop   <= 1'b0;
        end else if (head_load) begin
            head_state       <= HEAD_VALID;
            {dout_eop, dout} <= arr_rd_data;
        end else if (pop) begin
            head_state <= HEAD_EMPTY;
        end
    end

    assign pkt_inc = wr_accept && din_eop;
    assign pkt_dec = pop && dout_eop;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            pkt_count <= '0;
        end else if (PACKET_MODE != 0) begin
            case ({pkt_inc, pkt_dec})
                2'b10:   pkt_count <= pkt_count + CNT_W'(1);
                2'b01:   pkt_count <= pkt_count - CNT_W'(1);
                default: pkt_count <= pkt_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            overflow  <= overflow  | (wr_en && arr_full);
            underflow <= underflow | (rd_en && (head_state == HEAD_EMPTY));
        end
    end

    assign empty       = (head_state == HEAD_EMPTY);
    assign full        = arr_full;
    assign nearly_full = arr_nearly_full;
    assign data_count  = arr_count + CNT_W'(head_state == HEAD_VALID);
    assign prog_full   = ({1'b0, data_count} >= PF_THRESHOLD);
    assign prog_empty  = ({1'b0, data_count} <= PE_THRESHOLD);

endmodule

// File: tb/tb_fallthrough_pkt_fifo.sv
// Bench for fallthrough_pkt_fifo: one stream-mode and one packet-mode instance share the
// stimulus; a queue-level model of each is compared against the outputs every cycle.
module tb_fallthrough_pkt_fifo;

    localparam int WIDTH = 32;
    localparam int DEPTH_BITS = 3;
    localparam int DEPTH = 8;
    localparam int PF_THR = 4;
    localparam int PE_THR = 1;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [31:0] din;
    logic        din_eop;
    logic        wr_en;
    logic        rd_en;

    logic [31:0] dout [2];
    logic        dout_eop [2];
    logic        empty [2];
    logic        full [2];
    logic        nearly_full [2];
    logic        prog_full [2];
    logic        prog_empty [2];
    logic [3:0]  data_count [2];
    logic [3:0]  pkt_count [2];
    logic        overflow [2];
    logic        underflow [2];

    int checks = 0;
    int errors = 0;
    bit check_en = 1'b0;

    // Model: all stored words oldest first; entry 0 is on dout when mhv is set.
    logic [32:0] mw [2][DEPTH+2];
    int          msize [2];
    bit          mhv [2];
    bit          movf [2];
    bit          munf [2];
    bit          mzero [2];

    int step_arr;
    bit step_wr_ok;
    bit step_pop;
    bit step_permit;
    bit step_load;
    int cmp_arr;
    int next_word;

    always #5 clk = ~clk;

    fallthrough_pkt_fifo #(
        .WIDTH(WIDTH), .MAX_DEPTH_BITS(DEPTH_BITS), .PROG_FULL_THRESHOLD(PF_THR),
        .PROG_EMPTY_THRESHOLD(PE_THR), .PACKET_MODE(0)
    ) dut0 (
        .clk(clk), .reset_n(reset_n), .din(din), .din_eop(din_eop), .wr_en(wr_en), .rd_en(rd_en),
        .dout(dout[0]), .dout_eop(dout_eop[0]), .empty(empty[0]), .full(full[0]),
        .nearly_full(nearly_full[0]), .prog_full(prog_full[0]), .prog_empty(prog_empty[0]),
        .data_count(data_count[0]), .pkt_count(pkt_count[0]),
        .overflow(overflow[0]), .underflow(underflow[0])
    );

    fallthrough_pkt_fifo #(
        .WIDTH(WIDTH), .MAX_DEPTH_BITS(DEPTH_BITS), .PROG_FULL_THRESHOLD(PF_THR),
        .PROG_EMPTY_THRESHOLD(PE_THR), .PACKET_MODE(1)
    ) dut1 (
        .clk(clk), .reset_n(reset_n), .din(din), .din_eop(din_eop), .wr_en(wr_en), .rd_en(rd_en),
        .dout(dout[1]), .dout_eop(dout_eop[1]), .empty(empty[1]), .full(full[1]),
        .nearly_full(nearly_full[1]), .prog_full(prog_full[1]), .prog_empty(prog_empty[1]),
        .data_count(data_count[1]), .pkt_count(pkt_count[1]),
        .overflow(overflow[1]), .underflow(underflow[1])
    );

    function automatic int model_pkts(input int m);
        int n;
        n = 0;
        for (int i = 0; i < msize[m]; i++) begin
            if (mw[m][i][32]) n++;
        end
        return n;
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input logic w, input logic [31:0] d, input logic e, input logic r);
        wr_en   = w;
        din     = d;
        din_eop = e;
        rd_en   = r;
        @(posedge clk);
        #1;
    endtask

    task automatic doReset(input logic w, input logic r);
        reset_n = 1'b0;
        applyStimulus(w, $urandom, 1'b1, r);
        reset_n = 1'b1;
    endtask

    task automatic checkResetState();
        for (int m = 0; m < 2; m++) begin
            checkOutput($sformatf("rst%0d.empty", m), empty[m], 1);
            checkOutput($sformatf("rst%0d.full", m), full[m], 0);
            checkOutput($sformatf("rst%0d.nearly_full", m), nearly_full[m], 0);
            checkOutput($sformatf("rst%0d.prog_full", m), prog_full[m], 0);
            checkOutput($sformatf("rst%0d.prog_empty", m), prog_empty[m], 1);
            checkOutput($sformatf("rst%0d.data_count", m), data_count[m], 0);
            checkOutput($sformatf("rst%0d.pkt_count", m), pkt_count[m], 0);
            checkOutput($sformatf("rst%0d.overflow", m), overflow[m], 0);
            checkOutput($sformatf("rst%0d.underflow", m), underflow[m], 0);
            checkOutput($sformatf("rst%0d.dout", m), {dout_eop[m], dout[m]}, 0);
        end
    endtask

    // Reference model advances on each edge using the inputs as they stood before it.
    always @(posedge clk) begin
        for (int m = 0; m < 2; m++) begin
            if (!reset_n) begin
                msize[m] = 0;
                mhv[m]   = 1'b0;
                movf[m]  = 1'b0;
                munf[m]  = 1'b0;
                mzero[m] = 1'b1;
            end else begin
                step_arr    = msize[m] - int'(mhv[m]);
                step_wr_ok  = wr_en && (step_arr != DEPTH);
                step_pop    = rd_en && mhv[m];
                step_permit = (step_arr > 0) && ((m == 0) || (model_pkts(m) > 0) || (step_arr == DEPTH));
                step_load   = step_permit && (!mhv[m] || step_pop);
                if (wr_en && step_arr == DEPTH) movf[m] = 1'b1;
                if (rd_en && !mhv[m]) munf[m] = 1'b1;
                if (step_pop) begin
                    for (int i = 0; i < msize[m] - 1; i++) mw[m][i] = mw[m][i+1];
                    msize[m]--;
                end
                if (step_load) begin
                    mhv[m]   = 1'b1;
                    mzero[m] = 1'b0;
                end else if (step_pop) begin
                    mhv[m] = 1'b0;
                end
                if (step_wr_ok) begin
                    mw[m][msize[m]] = {din_eop, din};
                    msize[m]++;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (check_en) begin
            for (int m = 0; m < 2; m++) begin
                cmp_arr = msize[m] - int'(mhv[m]);
                checkOutput($sformatf("dut%0d.empty", m), empty[m], !mhv[m]);
                checkOutput($sformatf("dut%0d.full", m), full[m], cmp_arr == DEPTH);
                checkOutput($sformatf("dut%0d.nearly_full", m), nearly_full[m], cmp_arr >= DEPTH - 1);
                checkOutput($sformatf("dut%0d.data_count", m), data_count[m], msize[m]);
                checkOutput($sformatf("dut%0d.prog_full", m), prog_full[m], msize[m] >= PF_THR);
                checkOutput($sformatf("dut%0d.prog_empty", m), prog_empty[m], msize[m] <= PE_THR);
                checkOutput($sformatf("dut%0d.pkt_count", m), pkt_count[m], (m == 1) ? model_pkts(m) : 0);
                checkOutput($sformatf("dut%0d.overflow", m), overflow[m], movf[m]);
                checkOutput($sformatf("dut%0d.underflow", m), underflow[m], munf[m]);
                if (mhv[m]) begin
                    checkOutput($sformatf("dut%0d.dout", m), dout[m], mw[m][0][31:0]);
                    checkOutput($sformatf("dut%0d.dout_eop", m), dout_eop[m], mw[m][0][32]);
                end else if (mzero[m]) begin
                    checkOutput($sformatf("dut%0d.dout_reset", m), {dout_eop[m], dout[m]}, 0);
                end
            end
        end
    end

    initial begin
        #500000;
        errors++;
        $display("[TB] FAIL watchdog: time limit reached before the stimulus completed");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        reset_n = 1'b0;
        wr_en   = 1'b0;
        rd_en   = 1'b0;
        din     = '0;
        din_eop = 1'b0;
        applyStimulus(0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0);
        check_en = 1'b1;
        checkResetState();
        reset_n = 1'b1;

        $display("[TB] fill to capacity and overflow");
        for (int i = 1; i <= 10; i++) begin
            applyStimulus(1, i, 0, 0);
            if (i == 1) checkOutput("t1.empty_after_1st", empty[0], 1);
            if (i == 2) begin
                checkOutput("t1.empty_after_2nd", empty[0], 0);
                checkOutput("t1.dout_after_2nd", dout[0], 1);
            end
            if (i == 3) checkOutput("t1.prog_full_at_3", prog_full[0], 0);
            if (i == 4) checkOutput("t1.prog_full_at_4", prog_full[0], 1);
            if (i == 9) begin
                checkOutput("t1.full_at_9", full[0], 1);
                checkOutput("t1.count_at_9", data_count[0], 9);
                checkOutput("t1.overflow_at_9", overflow[0], 0);
            end
            if (i == 10) begin
                checkOutput("t1.overflow_at_10", overflow[0], 1);
                checkOutput("t1.count_at_10", data_count[0], 9);
            end
        end
        checkOutput("t1.model_size", msize[0], 9);

        $display("[TB] drain and underflow");
        for (int i = 1; i <= 9; i++) begin
            checkOutput("t2.dout_order", dout[0], i);
            checkOutput("t2.not_empty", empty[0], 0);
            applyStimulus(0, 0, 0, 1);
        end
        checkOutput("t2.empty_after_drain", empty[0], 1);
        checkOutput("t2.count_after_drain", data_count[0], 0);
        checkOutput("t2.prog_empty_after_drain", prog_empty[0], 1);
        checkOutput("t2.underflow_before", underflow[0], 0);
        applyStimulus(0, 0, 0, 1);
        checkOutput("t2.underflow_after", underflow[0], 1);

        $display("[TB] steady stream");
        doReset(0, 0);
        applyStimulus(1, 1, 1, 0);
        applyStimulus(1, 2, 1, 0);
        for (int k = 0; k < 20; k++) begin
            for (int m = 0; m < 2; m++) begin
                checkOutput($sformatf("t3.count%0d", m), data_count[m], 2);
                checkOutput($sformatf("t3.dout%0d", m), dout[m], (k == 0) ? 1 : (k == 1) ? 2 : 100 + k - 2);
            end
            applyStimulus(1, 100 + k, 1, 1);
        end

        $display("[TB] packet mode store-and-forward");
        doReset(0, 0);
        applyStimulus(1, 11, 0, 0);
        checkOutput("t4.empty_w1", empty[1], 1);
        applyStimulus(1, 12, 0, 0);
        checkOutput("t4.empty_w2", empty[1], 1);
        applyStimulus(1, 13, 1, 0);
        checkOutput("t4.empty_w3", empty[1], 1);
        checkOutput("t4.pkt_count_1", pkt_count[1], 1);
        applyStimulus(0, 0, 0, 0);
        checkOutput("t4.empty_after_eop", empty[1], 0);
        for (int j = 0; j < 3; j++) begin
            checkOutput("t4.dout", dout[1], 11 + j);
            checkOutput("t4.dout_eop", dout_eop[1], j == 2);
            applyStimulus(0, 0, 0, 1);
        end
        checkOutput("t4.pkt_count_0", pkt_count[1], 0);
        checkOutput("t4.empty_end", empty[1], 1);

        $display("[TB] packet mode cut-through");
        doReset(0, 0);
        next_word = 1;
        for (int c = 0; c < 12; c++) begin
            step_wr_ok = (msize[1] - int'(mhv[1])) != DEPTH;
            applyStimulus(1, next_word, 0, 0);
            if (step_wr_ok) next_word++;
        end
        checkOutput("t5.empty", empty[1], 0);
        checkOutput("t5.full", full[1], 1);
        checkOutput("t5.dout", dout[1], 1);
        checkOutput("t5.overflow", overflow[1], 1);
        for (int c = 0; c < 60 && next_word <= 12; c++) begin
            step_wr_ok = (msize[1] - int'(mhv[1])) != DEPTH;
            applyStimulus(1, next_word, 0, 1);
            if (step_wr_ok) next_word++;
        end
        checkOutput("t5.all_words_accepted", next_word, 13);

        $display("[TB] reset mid-stream");
        doReset(0, 0);
        for (int i = 1; i <= 10; i++) applyStimulus(1, 200 + i, 0, 0);
        for (int i = 0; i < 4; i++) applyStimulus(0, 0, 0, 1);
        checkOutput("t6.count_before", data_count[0], 5);
        checkOutput("t6.overflow_before", overflow[0], 1);
        doReset(1, 1);
        checkResetState();

        $display("[TB] randomized traffic");
        for (int c = 0; c < 800; c++) begin
            if ($urandom_range(0, 99) == 0) begin
                doReset(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            end else begin
                applyStimulus($urandom_range(0, 9) < 6, $urandom, $urandom_range(0, 3) == 0,
                              $urandom_range(0, 9) < 5);
            end
        end
        applyStimulus(0, 0, 0, 0);
        @(negedge clk);
        #1;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
